// File: rtl/sweep_location_filter.sv
// Servo sweep front-end: averages range samples per angle, rejects bad angles,
// and publishes the nearest valid return as a {angle, range} location word.
module sweep_location_filter #(
  parameter int          NUM_ANGLES        = 12,
  parameter int          SAMPLES_PER_ANGLE = 4,
  parameter int          SAMPLES_LOG2      = 2,
  parameter logic [7:0]  MIN_DIST          = 8'd2,
  parameter logic [7:0]  MAX_DIST          = 8'd200,
  parameter logic [23:0] TIMEOUT_CYCLES    = 24'd6_500_000
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        start,
  input  logic        sample_valid,
  input  logic [7:0]  sample_distance,
  input  logic [3:0]  sample_angle,
  output logic [3:0]  servo_angle,
  output logic        busy,
  output logic [11:0] location,
  output logic        new_data,
  output logic        no_target
);

  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, PUBLISH} state_t;

  localparam int              SUM_W      = 8 + SAMPLES_LOG2;
  localparam int              CNT_W      = SAMPLES_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SAMPLES_PER_ANGLE);
  localparam logic [3:0]      LAST_ANGLE = 4'(NUM_ANGLES - 1);

  state_t           state, state_n;
  logic [SUM_W-1:0] sum, sum_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic             angle_ok, angle_ok_n;
  logic [23:0]      timer, timer_n;
  logic [7:0]       best_r, best_r_n;
  logic [3:0]       best_angle, best_angle_n;
  logic             best_valid, best_valid_n;
  logic [3:0]       servo_angle_n;
  logic [11:0]      location_n;
  logic             new_data_n;
  logic             no_target_n;
  logic             accept;
  logic             in_range;
  logic [7:0]       avg;

  assign busy      = (state != IDLE);
  assign accept    = (state == ACCUM) && sample_valid && (sample_angle == servo_angle);
  assign in_range  = (sample_distance >= MIN_DIST) && (sample_distance <= MAX_DIST);
  assign avg       = sum[SUM_W-1:SAMPLES_LOG2];
  assign count_inc = count + 1'b1;

  always_ff @(posedge vclock) begin
    if (reset) begin
      state       <= IDLE;
      sum         <= '0;
      count       <= '0;
      angle_ok    <= 1'b0;
      timer       <= '0;
      best_r      <= '0;
      best_angle  <= '0;
      best_valid  <= 1'b0;
      servo_angle <= '0;
      location    <= '0;
      new_data    <= 1'b0;
      no_target   <= 1'b0;
    end else begin
      state       <= state_n;
      sum         <= sum_n;
      count       <= count_n;
      angle_ok    <= angle_ok_n;
      timer       <= timer_n;
      best_r      <= best_r_n;
      best_angle  <= best_angle_n;
      best_valid  <= best_valid_n;
      servo_angle <= servo_angle_n;
      location    <= location_n;
      new_data    <= new_data_n;
      no_target   <= no_target_n;
    end
  end

  always_comb begin
    state_n       = state;
    sum_n         = sum;
    count_n       = count;
    angle_ok_n    = angle_ok;
    timer_n       = timer;
    best_r_n      = best_r;
    best_angle_n  = best_angle;
    best_valid_n  = best_valid;
    servo_angle_n = servo_angle;
    location_n    = location;
    new_data_n    = 1'b0;
    no_target_n   = no_target;

    case (state)
      IDLE: begin
        if (start) begin
          state_n       = ACCUM;
          servo_angle_n = '0;
          sum_n         = '0;
          count_n       = '0;
          angle_ok_n    = 1'b1;
          timer_n       = '0;
          best_r_n      = 8'hFF;
          best_angle_n  = '0;
          best_valid_n  = 1'b0;
          no_target_n   = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
          count_n = count_inc;
          timer_n = '0;
          if (in_range) sum_n = sum + SUM_W'(sample_distance);
          else          angle_ok_n = 1'b0;
          if (count_inc == CNT_FULL) state_n = EVAL;
        end else if (timer == TIMEOUT_CYCLES - 24'd1) begin
          angle_ok_n = 1'b0;
          state_n    = EVAL;
        end else begin
          timer_n = timer + 24'd1;
        end
      end
      EVAL: begin
        // Strict compare so an equal average at a later angle never displaces the earlier one
        if (angle_ok && (avg < best_r)) begin
          best_r_n     = avg;
          best_angle_n = servo_angle;
          best_valid_n = 1'b1;
        end
        if (servo_angle == LAST_ANGLE) begin
          state_n = PUBLISH;
          if (best_valid_n) begin
            location_n = {best_angle_n, best_r_n};
            new_data_n = 1'b1;
          end else begin
            no_target_n = 1'b1;
          end
        end else begin
          servo_angle_n = servo_angle + 4'd1;
          sum_n         = '0;
          count_n       = '0;
          timer_n       = '0;
          angle_ok_n    = 1'b1;
          state_n       = ACCUM;
        end
      end
      PUBLISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sweep_location_filter.sv
// Directed bench for sweep_location_filter with a short timeout so the
// timeout path can be exercised cycle-exactly.
module tb_sweep_location_filter;

  localparam logic [23:0] TMO = 24'd40;

  logic        vclock = 1'b0;
  logic        reset;
  logic        start;
  logic        sample_valid;
  logic [7:0]  sample_distance;
  logic [3:0]  sample_angle;
  logic [3:0]  servo_angle;
  logic        busy;
  logic [11:0] location;
  logic        new_data;
  logic        no_target;

  int checks = 0;
  int passed = 0;
  int ndCount = 0;
  int ndBefore;
  logic [7:0] vec [12][4];

  sweep_location_filter #(.TIMEOUT_CYCLES(TMO)) dut (
    .vclock(vclock), .reset(reset), .start(start),
    .sample_valid(sample_valid), .sample_distance(sample_distance),
    .sample_angle(sample_angle), .servo_angle(servo_angle), .busy(busy),
    .location(location), .new_data(new_data), .no_target(no_target)
  );

  always #5 vclock = ~vclock;

  always @(negedge vclock) if (new_data === 1'b1) ndCount++;

  task automatic tick();
    @(posedge vclock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] a);
    sample_valid    = v;
    sample_distance = d;
    sample_angle    = a;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic fillAll(input logic [7:0] d);
    for (int a = 0; a < 12; a++)
      for (int s = 0; s < 4; s++) vec[a][s] = d;
  endtask

  task automatic startSweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("servo_after_start", {28'd0, servo_angle}, 32'd0);
  endtask

  // Four back-to-back samples then the EVAL cycle
  task automatic feedAngle(input int a);
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, vec[a][s], 4'(a));
    tick();
  endtask

  task automatic fullSweep();
    startSweep();
    for (int a = 0; a < 12; a++) feedAngle(a);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
    sample_distance = '0; sample_angle = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_location", {20'd0, location}, 32'h0);
    checkOutput("rst_new_data", {31'd0, new_data}, 32'd0);
    checkOutput("rst_no_target", {31'd0, no_target}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_servo", {28'd0, servo_angle}, 32'd0);

    // Nominal sweep, angle 5 nearest
    fillAll(8'd100);
    vec[5][0] = 8'd40; vec[5][1] = 8'd40; vec[5][2] = 8'd41; vec[5][3] = 8'd41;
    ndBefore = ndCount;
    fullSweep();
    checkOutput("nom_new_data", {31'd0, new_data}, 32'd1);
    checkOutput("nom_location", {20'd0, location}, 32'h528);
    checkOutput("nom_busy_publish", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("nom_busy_drop", {31'd0, busy}, 32'd0);
    checkOutput("nom_new_data_off", {31'd0, new_data}, 32'd0);
    checkOutput("nom_no_target", {31'd0, no_target}, 32'd0);
    checkOutput("nom_pulse_count", ndCount - ndBefore, 32'd1);

    // Tie at angles 3 and 7 with truncating average
    fillAll(8'd150);
    for (int s = 0; s < 4; s++) begin
      vec[3][s] = (s % 2 == 0) ? 8'd30 : 8'd31;
      vec[7][s] = (s % 2 == 0) ? 8'd30 : 8'd31;
    end
    fullSweep();
    checkOutput("tie_location", {20'd0, location}, 32'h31E);
    tick();

    // Outlier at angle 2 rejects that angle
    fillAll(8'd90);
    vec[2][0] = 8'd10; vec[2][1] = 8'd10; vec[2][2] = 8'd10; vec[2][3] = 8'd250;
    fullSweep();
    checkOutput("outlier_location", {20'd0, location}, 32'h05A);
    tick();

    // Mismatched sample dropped, then timeout at angle 4
    fillAll(8'd120);
    startSweep();
    for (int a = 0; a < 4; a++) feedAngle(a);
    checkOutput("tmo_servo_enter", {28'd0, servo_angle}, 32'd4);
    applyStimulus(1'b1, 8'd5, 4'd3);
    for (int i = 1; i < int'(TMO); i++) tick();
    checkOutput("tmo_servo_at_eval", {28'd0, servo_angle}, 32'd4);
    tick();
    checkOutput("tmo_servo_advance", {28'd0, servo_angle}, 32'd5);
    for (int a = 5; a < 12; a++) feedAngle(a);
    checkOutput("tmo_location", {20'd0, location}, 32'h078);
    tick();

    // Every sample out of range: no target
    fillAll(8'd255);
    ndBefore = ndCount;
    fullSweep();
    tick();
    checkOutput("nt_no_target", {31'd0, no_target}, 32'd1);
    checkOutput("nt_location_held", {20'd0, location}, 32'h078);
    tick(); tick();
    checkOutput("nt_no_target_hold", {31'd0, no_target}, 32'd1);
    checkOutput("nt_no_pulse", ndCount - ndBefore, 32'd0);

    // Start clears no_target; stray start mid-sweep ignored; reset aborts
    fillAll(8'd60);
    startSweep();
    checkOutput("nt_cleared", {31'd0, no_target}, 32'd0);
    for (int a = 0; a < 3; a++) feedAngle(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("stray_start_servo", {28'd0, servo_angle}, 32'd3);
    checkOutput("stray_start_busy", {31'd0, busy}, 32'd1);
    for (int a = 3; a < 6; a++) feedAngle(a);
    applyStimulus(1'b1, 8'd60, 4'd6);
    applyStimulus(1'b1, 8'd60, 4'd6);
    checkOutput("pre_rst_servo", {28'd0, servo_angle}, 32'd6);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_location", {20'd0, location}, 32'h0);
    checkOutput("midrst_servo", {28'd0, servo_angle}, 32'd0);
    tick();
    checkOutput("rst_start_ignored", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sweep_location_filter.md
Name: sweep_location_filter

Overview:
- Ultrasound front-end stage sitting directly upstream of the VGA writer.
- Steps the servo through NUM_ANGLES positions and collects SAMPLES_PER_ANGLE distance readings at each.
- Averages the readings per angle, rejects bad angles, and picks the nearest return.
- Publishes it as the 12-bit polar location word with a one-cycle new_data strobe that the display consumes at its next vsync.

Parameters:
- NUM_ANGLES, 12, servo positions per sweep; angle index 0..NUM_ANGLES-1, max 16.
- SAMPLES_PER_ANGLE, 4, readings averaged per angle; must be a power of 2.
- SAMPLES_LOG2, 2, log2(SAMPLES_PER_ANGLE).
- MIN_DIST, 8'd2, smallest in-range distance (inclusive).
- MAX_DIST, 8'd200, largest in-range distance (inclusive).
- TIMEOUT_CYCLES, 24'd6_500_000, idle cycles at one angle before giving up on it (100 ms at 65 MHz).

Ports:
- vclock  input  1  65 MHz system clock.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse that begins a sweep.
- sample_valid  input  1  one-cycle strobe; sample_distance and sample_angle are valid in that cycle.
- sample_distance  input  8  measured range, one count per unit of grid distance.
- sample_angle  input  4  angle index the sample was taken at.
- servo_angle  output  4  angle index the servo must be driven to.
- busy  output  1  high from the cycle after an accepted start until the cycle after PUBLISH.
- location  output  12  {angle[3:0], r[7:0]} of the nearest valid return; held between sweeps.
- new_data  output  1  one-cycle strobe when location is updated.
- no_target  output  1  level; set when a sweep ends with no valid angle, cleared on next accepted start.

Behaviour:
- Reset values:
  - Outputs: location=0, new_data=0, no_target=0, busy=0, servo_angle=0.
  - Internal: FSM in IDLE; sum, sample count, valid flag, timeout counter and best registers cleared.
  - Reset overrides everything else and aborts any sweep in progress; no new_data is emitted.
- States: IDLE, ACCUM, EVAL, PUBLISH.
- IDLE:
  - start=1 moves to ACCUM at angle 0: servo_angle=0, sum=0, count=0, angle_ok=1, timer=0.
  - Sets best_r=8'hFF and best_valid=0; clears no_target.
- ACCUM:
  - Accept a sample only if sample_valid=1 and sample_angle==servo_angle; other samples are dropped silently.
  - On accept: count+1 and timer cleared.
    - Distance in [MIN_DIST, MAX_DIST]: sum += distance. The sum is (8+SAMPLES_LOG2) bits and cannot overflow.
    - Distance out of range: angle_ok cleared.
  - When count reaches SAMPLES_PER_ANGLE, go to EVAL next cycle.
  - Otherwise timer increments every cycle with no accept. At TIMEOUT_CYCLES-1, clear angle_ok and go to EVAL.
- EVAL (one cycle; samples arriving here are dropped):
  - avg = sum >> SAMPLES_LOG2 (truncating).
  - If angle_ok and avg < best_r (strict), load best_r=avg, best_angle=servo_angle, best_valid=1. Ties keep the lower angle.
  - If servo_angle == NUM_ANGLES-1, go to PUBLISH.
  - Otherwise increment servo_angle, clear sum/count/timer, set angle_ok=1, and return to ACCUM.
- PUBLISH (one cycle):
  - best_valid=1: location <= {best_angle, best_r}, with new_data=1 registered the same cycle.
  - best_valid=0: location unchanged, new_data stays 0, no_target <= 1.
  - Then go to IDLE.
- Latency: last sample accepted in cycle N; EVAL in N+1; location and new_data visible in N+2. busy drops in N+3.
- start is ignored outside IDLE, and start coincident with reset is ignored.
- new_data is never high for more than one consecutive cycle.

Test Plan:
- Nominal sweep: all 12 angles get 4 samples of 100, except angle 5 with 40,40,41,41 (avg 40) → new_data pulse once; location=12'h528; no_target=0.
- Tie and truncation: angles 3 and 7 both give samples 30,31,30,31 (avg 30), all others 150 → location=12'h31E.
- Outlier rejection: angle 2 samples 10,10,10,250 and all others 90 → angle 2 rejected; location={0,90}=12'h05A.
- Mismatch and timeout: at angle 4, sample_valid with sample_angle=3 is dropped. No further samples at angle 4 → EVAL after exactly TIMEOUT_CYCLES idle cycles, and servo_angle advances to 5.
- No target: every sample 255 → no new_data; location holds its previous value; no_target=1 until the next start.
- Reset mid-sweep at angle 6 → next cycle busy=0, location=0, servo_angle=0. A start pulse during a sweep has no effect.
